bcd_counter4: RTL and testbench

Four-digit BCD up/down counter with a built-in prescaler, feeding the BCD-to-7-segment decoder stage. Each digit nibble drives one decoder instance or a digit scanner. Bit 0 of each nibble is the decoder's LSB input, bit 3 its MSB. Count values are always valid BCD (0-9 per nibble), so the downstream decoder never sees codes 10-15.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_counter4_if.sv | 17 +
 rtl/bcd_digit.sv | 31 +++
 rtl/bcd_counter4.sv | 73 +++++++
 tb/tb_bcd_counter4.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, max digit value, packed 4-digit type and validity check.
// Pure declarations; no timing or flow control.
package bcd_pkg;
    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef logic [4*DIGIT_W-1:0] bcd4_t;

    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_counter4_if.sv
// Control/load inputs and count/flag outputs of the 4-digit BCD counter.
// No handshake: controls are level/pulse signals, outputs are registered pulses and the count.
interface bcd_counter4_if;
    import bcd_pkg::*;

    logic  en;
    logic  up;
    logic  load;
    bcd4_t load_val;
    bcd4_t digits;
    logic  tick;
    logic  carry;
    logic  load_err;

    modport master (output en, up, load, load_val, input digits, tick, carry, load_err);
    modport slave  (input en, up, load, load_val, output digits, tick, carry, load_err);
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit with load and ripple step; nib updates one edge after load/step, step_out is combinational.
// No backpressure: a step_in is always consumed on the edge it is presented.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               step_in,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_nib,
    output logic [DIGIT_W-1:0] nib,
    output logic               step_out
);
    // Carry when stepping up past 9, borrow when stepping down past 0.
    assign step_out = step_in && (up ? (nib == BCD_MAX) : (nib == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            nib <= '0;
        end else if (load) begin
            nib <= load_nib;
        end else if (step_in) begin
            if (up) begin
                nib <= (nib == BCD_MAX) ? '0 : nib + 4'd1;
            end else begin
                nib <= (nib == '0) ? BCD_MAX : nib - 4'd1;
            end
        end
    end
endmodule

// File: rtl/bcd_counter4.sv
// 4-digit BCD up/down counter with prescaler; digits and flags change one edge after step/load/reset.
// No backpressure: steps are never stalled; a valid load overrides (discards) a coincident step.
module bcd_counter4
    import bcd_pkg::*;
#(
    parameter int PRESCALE = 50000000,
    parameter int PRE_W    = 26
) (
    input  logic             clk,
    input  logic             rst,
    bcd_counter4_if.slave    bus
);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;
    logic             load_ok;
    logic             load_bad;
    logic             step_due;
    logic             step;
    logic [4:0]       chain;
    bcd4_t            digits_q;
    logic             tick_q;
    logic             carry_q;
    logic             load_err_q;

    always_comb begin
        load_ok  = bus.load
                && bcd_valid(bus.load_val[3:0])   && bcd_valid(bus.load_val[7:4])
                && bcd_valid(bus.load_val[11:8])  && bcd_valid(bus.load_val[15:12]);
        load_bad = bus.load && !load_ok;
        step_due = bus.en && (pre == PRE_LAST);
        step     = step_due && !load_ok;
    end

    assign chain[0] = step;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .step_in  (chain[i]),
            .up       (bus.up),
            .load     (load_ok),
            .load_nib (bus.load_val[i*DIGIT_W +: DIGIT_W]),
            .nib      (digits_q[i*DIGIT_W +: DIGIT_W]),
            .step_out (chain[i+1])
        );
    end

    // A rejected load leaves the prescaler running, so a coincident step still happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            tick_q     <= 1'b0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (load_ok) begin
                pre <= '0;
            end else if (bus.en) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
            end
            tick_q     <= step;
            carry_q    <= chain[4];
            load_err_q <= load_bad;
        end
    end

    assign bus.digits   = digits_q;
    assign bus.tick     = tick_q;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter4.sv
// Directed bench: PRESCALE=4 instance for timing/gating/collisions, PRESCALE=1 instance for
// table-driven wrap/borrow vectors and load validation.
module tb_bcd_counter4;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_counter4_if b4 ();
    bcd_counter4_if b1 ();

    bcd_counter4 #(.PRESCALE(4), .PRE_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    bcd_counter4 #(.PRESCALE(1), .PRE_W(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        logic [15:0] lv;
        logic        up;
        logic [15:0] exp_d;
        logic        exp_t;
        logic        exp_c;
    } vec_t;

    vec_t vecs [7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [15:0] d, input logic t, input logic c);
        chk({nm, "_digits"}, b4.digits, d);
        chk({nm, "_tick"},   {15'd0, b4.tick},  {15'd0, t});
        chk({nm, "_carry"},  {15'd0, b4.carry}, {15'd0, c});
    endtask

    task automatic chk1(input string nm, input logic [15:0] d, input logic t, input logic c);
        chk({nm, "_digits"}, b1.digits, d);
        chk({nm, "_tick"},   {15'd0, b1.tick},  {15'd0, t});
        chk({nm, "_carry"},  {15'd0, b1.carry}, {15'd0, c});
    endtask

    task automatic load1(input logic [15:0] v);
        b1.en = 1'b0; b1.load = 1'b1; b1.load_val = v;
        cyc();
        b1.load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h9999, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[1] = '{16'h1000, 1'b0, 16'h0999, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 1'b0, 16'h9999, 1'b1, 1'b1};
        vecs[3] = '{16'h0010, 1'b0, 16'h0009, 1'b1, 1'b0};
        vecs[4] = '{16'h0099, 1'b1, 16'h0100, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 1'b1, 16'h1235, 1'b1, 1'b0};
        vecs[6] = '{16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        b4.en = 1'b1; b4.up = 1'b1; b4.load = 1'b0; b4.load_val = '0;
        b1.en = 1'b0; b1.up = 1'b1; b1.load = 1'b0; b1.load_val = '0;

        // reset and count up at PRESCALE=4
        repeat (2) begin
            cyc();
            chk4("reset", 16'h0000, 1'b0, 1'b0);
            chk("reset_load_err", {15'd0, b4.load_err}, 16'h0000);
        end
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            int n;
            cyc();
            n = i / 4;
            chk4("count_up", 16'((n / 10) << 4 | (n % 10)), (i % 4) == 0, 1'b0);
        end
        b4.en = 1'b0;

        // wrap/borrow vectors at PRESCALE=1
        for (int k = 0; k < 7; k++) begin
            load1(vecs[k].lv);
            chk1("vec_load", vecs[k].lv, 1'b0, 1'b0);
            b1.en = 1'b1; b1.up = vecs[k].up;
            cyc();
            chk1("vec_step", vecs[k].exp_d, vecs[k].exp_t, vecs[k].exp_c);
            b1.en = 1'b0;
        end

        // up wrap then next step clears carry
        load1(16'h9999);
        b1.en = 1'b1; b1.up = 1'b1;
        cyc(); chk1("wrap_up", 16'h0000, 1'b1, 1'b1);
        cyc(); chk1("after_wrap", 16'h0001, 1'b1, 1'b0);
        b1.en = 1'b0;

        // invalid load
        load1(16'h0042);
        b1.load = 1'b1; b1.load_val = 16'h12A4;
        cyc();
        chk("bad_load_err", {15'd0, b1.load_err}, 16'h0001);
        chk("bad_load_digits", b1.digits, 16'h0042);
        b1.load = 1'b0;
        cyc();
        chk("bad_load_err_pulse", {15'd0, b1.load_err}, 16'h0000);
        chk("bad_load_hold", b1.digits, 16'h0042);
        load1(16'h1234);
        chk("good_load_digits", b1.digits, 16'h1234);
        chk("good_load_err", {15'd0, b1.load_err}, 16'h0000);

        // rejected load with a step due: the step still happens
        b1.en = 1'b1; b1.up = 1'b1; b1.load = 1'b1; b1.load_val = 16'h0F00;
        cyc();
        chk1("bad_load_step", 16'h1235, 1'b1, 1'b0);
        chk("bad_load_step_err", {15'd0, b1.load_err}, 16'h0001);

        // held load suppresses steps
        b1.load_val = 16'h0300;
        repeat (3) begin
            cyc();
            chk1("held_load", 16'h0300, 1'b0, 1'b0);
        end
        b1.load = 1'b0; b1.en = 1'b0;

        // enable gating at PRESCALE=4
        b4.load = 1'b1; b4.load_val = 16'h0000; b4.en = 1'b0; b4.up = 1'b1;
        cyc();
        b4.load = 1'b0; b4.en = 1'b1;
        repeat (2) begin cyc(); chk4("gate_run", 16'h0000, 1'b0, 1'b0); end
        b4.en = 1'b0;
        repeat (2) begin cyc(); chk4("gate_off", 16'h0000, 1'b0, 1'b0); end
        b4.en = 1'b1;
        cyc(); chk4("gate_pre3", 16'h0000, 1'b0, 1'b0);
        cyc(); chk4("gate_step", 16'h0001, 1'b1, 1'b0);

        // valid load colliding with a due step
        repeat (3) begin cyc(); chk4("pre_load", 16'h0001, 1'b0, 1'b0); end
        b4.load = 1'b1; b4.load_val = 16'h0500;
        cyc(); chk4("load_collide", 16'h0500, 1'b0, 1'b0);
        b4.load = 1'b0;
        repeat (3) begin cyc(); chk4("post_load", 16'h0500, 1'b0, 1'b0); end
        cyc(); chk4("post_load_step", 16'h0501, 1'b1, 1'b0);

        // reset colliding with a due step
        repeat (3) begin cyc(); chk4("pre_rst", 16'h0501, 1'b0, 1'b0); end
        rst = 1'b1;
        cyc(); chk4("rst_collide", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        b4.up = 1'b0;
        repeat (3) begin cyc(); chk4("post_rst", 16'h0000, 1'b0, 1'b0); end
        cyc(); chk4("post_rst_step", 16'h9999, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
